mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 142 ++++++++++++++
 tb/tb_mem_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-requester SRAM arbiter, round-robin (fixed priority to requester 0 when MEM_ARB_FIXED_PRIO_EN is defined).
// GNT 1 cycle after sampling, RVALID 3 cycles after; requests are only sampled while idle (BUSY low).
module mem_arb #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          MEM_CE,
    output logic          MEM_CSB,
    output logic          MEM_WEB,
    output logic          MEM_OEB,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_IDATA,
    input  logic [DW-1:0] MEM_ODATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant;
    logic          win;
    logic          cur;
    logic          cur_we;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          last;
`endif

    // Winner selection: with a tie, round-robin picks whoever was not granted last.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        win = ~REQ0;
`else
        win = (REQ0 & REQ1) ? ~last : REQ1;
`endif
        sel_we    = win ? WE1    : WE0;
        sel_addr  = win ? ADDR1  : ADDR0;
        sel_wdata = win ? WDATA1 : WDATA0;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (REQ0 | REQ1) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = cur_we ? IDLE : RDWAIT;
            RDWAIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign BUSY = (state != IDLE);

    // Strobes and grant pulses are registered at the sampling edge so they
    // are valid for exactly the ACCESS cycle; address/data simply hold after.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            RVALID0   <= 1'b0;
            RVALID1   <= 1'b0;
            RDATA     <= '0;
            MEM_CE    <= 1'b0;
            MEM_CSB   <= 1'b1;
            MEM_WEB   <= 1'b1;
            MEM_OEB   <= 1'b1;
            MEM_ADDR  <= '0;
            MEM_IDATA <= '0;
            cur       <= 1'b0;
            cur_we    <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else begin
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            MEM_CE  <= 1'b0;
            MEM_CSB <= 1'b1;
            MEM_WEB <= 1'b1;
            MEM_OEB <= 1'b1;
            if (grant) begin
                cur       <= win;
                cur_we    <= sel_we;
                MEM_ADDR  <= sel_addr;
                MEM_IDATA <= sel_wdata;
                MEM_CE    <= 1'b1;
                MEM_CSB   <= 1'b0;
                MEM_WEB   <= ~sel_we;
                MEM_OEB   <= sel_we;
                GNT0      <= ~win;
                GNT1      <= win;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last      <= win;
`endif
            end
            if (state == RDWAIT) begin
                RDATA   <= MEM_ODATA;
                RVALID0 <= ~cur;
                RVALID1 <= cur;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: vector table of single transactions plus
// hand sequences for continuous contention, busy-time pulses and mid-read reset.
module tb_mem_arb;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1, BUSY;
    logic [DW-1:0] RDATA;
    logic          MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_IDATA;
    logic [DW-1:0] MEM_ODATA;

    always #5 CLK = ~CLK;

    mem_arb #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .BUSY(BUSY),
        .MEM_CE(MEM_CE), .MEM_CSB(MEM_CSB), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
        .MEM_ADDR(MEM_ADDR), .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA)
    );

    // Synchronous SRAM model: read data appears the cycle after the strobe.
    logic [DW-1:0] mem [0:65535];
    always @(posedge CLK) begin
        if (MEM_CE && !MEM_CSB) begin
            if (!MEM_WEB) mem[MEM_ADDR] <= MEM_IDATA;
            if (!MEM_OEB) MEM_ODATA <= mem[MEM_ADDR];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {GNT1, GNT0, RVALID1, RVALID0, BUSY, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB},
            9'b0_0_0_0_0_0_1_1_1);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_addr"}, MEM_ADDR, 0);
        chk({tag, "_idata"}, MEM_IDATA, 0);
    endtask

    typedef struct {
        logic          r0, w0, r1, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    gnt;    // {GNT1,GNT0}
        logic          wr;     // winner's access is a write
        logic [AW-1:0] addr;
        logic [DW-1:0] idata;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vt [10];
    logic exp_ord [4];
    logic [1:0] tie3;

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        tie3 = 2'b01;
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        tie3 = 2'b10;
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        //           r0    w0    r1    w1    a0        a1        d0     d1     gnt    wr    addr      idata  rdata
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 8'hA5, 8'h00, 2'b01, 1'b1, 16'h0010, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 8'h00, 8'h3C, 2'b10, 1'b0, 16'h0010, 8'h3C, 8'hA5};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0030, 8'h11, 8'h22, 2'b01, 1'b1, 16'h0020, 8'h11, 8'h00};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h0030, 8'h22, 8'h22, tie3,  1'b1, 16'h0030, 8'h22, 8'h00};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0040, 8'h00, 8'h33, 2'b10, 1'b1, 16'h0040, 8'h33, 8'h00};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 16'h0020, 8'h00, 8'h11};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 8'h00, 8'h5A, 2'b10, 1'b0, 16'h0030, 8'h5A, 8'h22};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0010, 8'h00, 8'h00, 2'b01, 1'b0, 16'h0040, 8'h00, 8'h33};
        vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'hFF, 8'h00, 2'b01, 1'b1, 16'hFFFF, 8'hFF, 8'h00};
        vt[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 8'h00, 8'h00, 2'b10, 1'b0, 16'hFFFF, 8'h00, 8'hFF};

        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        #12;
        chk_reset("reset");
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            REQ0 = vt[i].r0; WE0 = vt[i].w0; ADDR0 = vt[i].a0; WDATA0 = vt[i].d0;
            REQ1 = vt[i].r1; WE1 = vt[i].w1; ADDR1 = vt[i].a1; WDATA1 = vt[i].d1;
            @(posedge CLK); #1;
            chk($sformatf("v%0d_gnt", i), {GNT1, GNT0}, vt[i].gnt);
            chk($sformatf("v%0d_strobes", i), {BUSY, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB},
                {1'b1, 1'b1, 1'b0, ~vt[i].wr, vt[i].wr});
            chk($sformatf("v%0d_addr", i), MEM_ADDR, vt[i].addr);
            chk($sformatf("v%0d_idata", i), MEM_IDATA, vt[i].idata);
            REQ0 = 1'b0; REQ1 = 1'b0;
            if (vt[i].wr) begin
                @(posedge CLK); #1;
                chk($sformatf("v%0d_wr_done", i), {BUSY, GNT1, GNT0, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB},
                    7'b0_0_0_0_1_1_1);
                chk($sformatf("v%0d_addr_hold", i), MEM_ADDR, vt[i].addr);
            end else begin
                @(posedge CLK); #1;
                chk($sformatf("v%0d_rdwait", i),
                    {BUSY, GNT1, GNT0, RVALID1, RVALID0, MEM_CE, MEM_CSB, MEM_WEB, MEM_OEB},
                    9'b1_0_0_0_0_0_1_1_1);
                @(posedge CLK); #1;
                chk($sformatf("v%0d_rvalid", i), {RVALID1, RVALID0}, vt[i].gnt);
                chk($sformatf("v%0d_rdata", i), RDATA, vt[i].rdata);
                chk($sformatf("v%0d_busy_end", i), BUSY, 0);
                @(posedge CLK); #1;
                chk($sformatf("v%0d_rvalid_pulse", i), {RVALID1, RVALID0}, 2'b00);
                chk($sformatf("v%0d_rdata_hold", i), RDATA, vt[i].rdata);
            end
        end

        // Both requesters hold writes continuously; expect alternation (or 0 every time).
        begin
            int ng = 0;
            int last_c = 0;
            @(negedge CLK);
            REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 16'h0100; WDATA0 = 8'hA0;
            REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 16'h0101; WDATA1 = 8'hB1;
            for (int c = 0; c < 20 && ng < 4; c++) begin
                @(posedge CLK); #1;
                chk("hold_gnt_excl", GNT0 & GNT1, 0);
                if (GNT0 | GNT1) begin
                    chk($sformatf("hold_order%0d", ng), GNT1, exp_ord[ng]);
                    if (ng > 0) chk("hold_spacing", c - last_c, 2);
                    last_c = c;
                    ng++;
                end
            end
            REQ0 = 1'b0; REQ1 = 1'b0;
            chk("hold_grant_count", ng, 4);
            @(posedge CLK); #1;
            chk("hold_idle", BUSY, 0);
        end

        // One-cycle REQ0 pulse while requester 1's read is in flight is ignored.
        @(negedge CLK);
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 16'h0010;
        @(posedge CLK); #1;
        chk("pulse_gnt1", {GNT1, GNT0}, 2'b10);
        REQ1 = 1'b0;
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 16'h0300; WDATA0 = 8'h77;
        @(posedge CLK); #1;
        REQ0 = 1'b0;
        @(posedge CLK); #1;
        chk("pulse_rvalid1", {RVALID1, RVALID0}, 2'b10);
        chk("pulse_rdata", RDATA, 8'hA5);
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            chk("pulse_no_gnt0", GNT0, 0);
            chk("pulse_no_access", {MEM_CE, MEM_CSB}, 2'b01);
        end

        // Reset in RDWAIT of a requester-0 read: async clear, no RVALID, fresh tie.
        @(negedge CLK);
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 16'h0010;
        @(posedge CLK); #1;
        chk("rst_gnt0", {GNT1, GNT0}, 2'b01);
        REQ0 = 1'b0;
        @(posedge CLK); #3;
        RST = 1'b1;
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 16'h0400; WDATA0 = 8'h44;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 16'h0500; WDATA1 = 8'h55;
        #1;
        chk_reset("rst_async");
        @(posedge CLK); #1;
        chk_reset("rst_held");
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_first_tie", {GNT1, GNT0}, 2'b01);
        chk("rst_first_addr", MEM_ADDR, 16'h0400);
        REQ0 = 1'b0; REQ1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk("rst_no_rvalid", {RVALID1, RVALID0}, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
